// File: rtl/efpga_clk_sel_pkg.sv
// Shared types and helpers for the eFPGA clock-select controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package efpga_clk_sel_pkg;

  localparam int NUM_CLK_SRC = 6;

  typedef logic [2:0] clk_sel_t;

  typedef enum logic [2:0] {
    IDLE,
    QUIESCE,
    GATE,
    SWITCH,
    UNGATE,
    DONE
  } clk_sel_state_e;

  // Sources 0..NUM_CLK_SRC-1 exist on the mux tree; anything above is rejected.
  function automatic logic sel_valid(input clk_sel_t sel);
    return (int'(sel) < NUM_CLK_SRC);
  endfunction

endpackage

// File: rtl/efpga_clk_sel_timer.sv
// Loadable down-counter shared by the quiesce/gate/settle/ungate phases.
// Latency: load or decrement visible the cycle after the request.
// Backpressure: none; saturates at zero instead of wrapping.
module efpga_clk_sel_timer #(
  parameter int unsigned W = 9
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_d, cnt_q;
  logic         zero_d, zero_q;

  // Load wins over decrement; a decrement at zero is dropped so the count never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
    zero_d = (cnt_d == '0);
  end

  // Count and its zero flag are registered together so zero_o is glitch-free.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= zero_d;
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/efpga_clk_sel_ctrl.sv
// Sequences a glitch-safe eFPGA clock source change: quiesce, gate, select, settle, ungate.
// Latency: accept to done_o = 1 + GATE + SETTLE + GATE + 1 cycles once quiesce is acked.
// Backpressure: req_ready_o only high in IDLE; requests must be held until accepted.
module efpga_clk_sel_ctrl
  import efpga_clk_sel_pkg::*;
#(
  parameter logic [2:0]  RESET_SEL      = 3'd1,
  parameter int unsigned GATE_CYCLES    = 4,
  parameter int unsigned SETTLE_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req_valid_i,
  input  logic [2:0] req_sel_i,
  output logic       req_ready_o,
  output logic       quiesce_req_o,
  input  logic       quiesce_ack_i,
  output logic       efpga_clk_en_o,
  output logic [2:0] sel_clk_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic       timeout_o
);

  localparam int unsigned MAX_GS  = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CNT_MAX = (MAX_GS > TIMEOUT_CYCLES) ? MAX_GS : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] GATE_LD   = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LD    = CNT_W'(TIMEOUT_CYCLES - 1);

  clk_sel_state_e   state_d, state_q;
  clk_sel_t         sel_d, sel_q;
  clk_sel_t         tgt_d, tgt_q;
  logic             en_d, en_q;
  logic             qreq_d, qreq_q;
  logic             busy_d, busy_q;
  logic             done_d, done_q;
  logic             err_d, err_q;
  logic             tmo_d, tmo_q;
  logic             rdy_d, rdy_q;
  logic             tmr_load, tmr_dec, tmr_zero;
  logic [CNT_W-1:0] tmr_val;

  efpga_clk_sel_timer #(.W(CNT_W)) u_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  // Next-state and next-output decode; the select only moves while the gate is closed.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    tgt_d    = tgt_q;
    en_d     = en_q;
    qreq_d   = qreq_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    tmo_d    = tmo_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i && rdy_q) begin
          if (!sel_valid(req_sel_i)) begin
            err_d = 1'b1;
          end else if (req_sel_i == sel_q) begin
            done_d = 1'b1;
          end else begin
            state_d  = QUIESCE;
            tgt_d    = req_sel_i;
            qreq_d   = 1'b1;
            busy_d   = 1'b1;
            tmo_d    = 1'b0;
            tmr_load = 1'b1;
            tmr_val  = TMO_LD;
          end
        end
      end
      QUIESCE: begin
        // An unresponsive fabric must not wedge the switch: gate anyway and flag it.
        if (quiesce_ack_i || tmr_zero) begin
          tmo_d    = tmo_q | ~quiesce_ack_i;
          state_d  = GATE;
          en_d     = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = GATE_LD;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      GATE: begin
        if (tmr_zero) begin
          state_d  = SWITCH;
          sel_d    = tgt_q;
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LD;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      SWITCH: begin
        if (tmr_zero) begin
          state_d  = UNGATE;
          en_d     = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = GATE_LD;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      UNGATE: begin
        if (tmr_zero) begin
          state_d = DONE;
          qreq_d  = 1'b0;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    rdy_d = (state_d == IDLE);
  end

  // State and every output are flops; reset reopens the gate on the reset source.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sel_q   <= RESET_SEL;
      tgt_q   <= RESET_SEL;
      en_q    <= 1'b1;
      qreq_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      tgt_q   <= tgt_d;
      en_q    <= en_d;
      qreq_q  <= qreq_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      rdy_q   <= rdy_d;
    end
  end

  assign req_ready_o    = rdy_q;
  assign quiesce_req_o  = qreq_q;
  assign efpga_clk_en_o = en_q;
  assign sel_clk_o      = sel_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign timeout_o      = tmo_q;

endmodule

// File: tb/tb_efpga_clk_sel_ctrl.sv
// Bench for the eFPGA clock-select controller.
// Latency: n/a.
// Backpressure: n/a.
module tb_efpga_clk_sel_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic [2:0] req_sel;
  logic       req_ready;
  logic       qreq;
  logic       ack;
  logic       en;
  logic [2:0] sel_clk;
  logic       busy;
  logic       done;
  logic       err;
  logic       tmo;

  int tests = 0;
  int fails = 0;

  // Reference state: currently selected source and sticky timeout flag.
  logic [2:0] model_sel;
  logic       model_to;

  always #5 clk = ~clk;

  efpga_clk_sel_ctrl dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_valid_i    (req_valid),
    .req_sel_i      (req_sel),
    .req_ready_o    (req_ready),
    .quiesce_req_o  (qreq),
    .quiesce_ack_i  (ack),
    .efpga_clk_en_o (en),
    .sel_clk_o      (sel_clk),
    .busy_o         (busy),
    .done_o         (done),
    .err_o          (err),
    .timeout_o      (tmo)
  );

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_sel = 3'd0; ack = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (sel_clk !== 3'd1 || en !== 1'b1) begin
      fails++; $display("FAIL reset_hold: sel=%0d en=%b, want sel=1 en=1", sel_clk, en);
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    tests++;
    if (sel_clk !== 3'd1) begin fails++; $display("FAIL reset_sel: got %0d want 1", sel_clk); end
    tests++;
    if (en !== 1'b1) begin fails++; $display("FAIL reset_en: got %b want 1", en); end
    tests++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    tests++;
    if ({qreq, busy, done, err, tmo} !== 5'b0) begin
      fails++; $display("FAIL reset_flags: {qreq,busy,done,err,to}=%b want 00000", {qreq, busy, done, err, tmo});
    end
    model_sel = 3'd1; model_to = 1'b0;
  endtask

  task automatic test_invalid();
    int busy_seen = 0;
    for (int i = 0; i < 2; i++) begin
      req_valid = 1'b1; req_sel = 3'(6 + i);
      @(negedge clk);
      req_valid = 1'b0;
      if (busy === 1'b1) busy_seen++;
      tests++;
      if (err !== 1'b1 || done !== 1'b0) begin
        fails++; $display("FAIL invalid_err sel=%0d: err=%b done=%b want err=1 done=0", 6 + i, err, done);
      end
      @(negedge clk);
      if (busy === 1'b1) busy_seen++;
      tests++;
      if (err !== 1'b0 || sel_clk !== 3'd1 || en !== 1'b1) begin
        fails++; $display("FAIL invalid_after sel=%0d: err=%b sel=%0d en=%b want 0/1/1", 6 + i, err, sel_clk, en);
      end
    end
    tests++;
    if (busy_seen != 0) begin fails++; $display("FAIL invalid_busy: busy seen %0d times want 0", busy_seen); end
  endtask

  task automatic test_same_sel();
    req_valid = 1'b1; req_sel = 3'd1;
    @(negedge clk);
    req_valid = 1'b0;
    tests++;
    if (done !== 1'b1 || err !== 1'b0) begin
      fails++; $display("FAIL same_done: done=%b err=%b want 1/0", done, err);
    end
    tests++;
    if (qreq !== 1'b0 || en !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL same_quiet: qreq=%b en=%b busy=%b want 0/1/0", qreq, en, busy);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || sel_clk !== 3'd1) begin
      fails++; $display("FAIL same_after: done=%b sel=%0d want 0/1", done, sel_clk);
    end
  endtask

  task automatic test_switch();
    int en_fall = -1, sel_chg = -1, en_rise = -1, done_k = -1, viol = 0;
    logic [2:0] prev_sel = sel_clk;
    ack = 1'b1;
    req_valid = 1'b1; req_sel = 3'd3;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 25; k++) begin
      if (en_fall < 0 && en === 1'b0) en_fall = k;
      if (sel_chg < 0 && sel_clk === 3'd3) sel_chg = k;
      if (en_fall >= 0 && en_rise < 0 && en === 1'b1) en_rise = k;
      if (done_k < 0 && done === 1'b1) done_k = k;
      if (sel_clk !== prev_sel && en !== 1'b0) viol++;
      prev_sel = sel_clk;
      @(negedge clk);
    end
    tests++;
    if (en_fall != 1) begin fails++; $display("FAIL switch_en_fall: cycle %0d want 1", en_fall); end
    tests++;
    if (sel_chg != 5) begin fails++; $display("FAIL switch_sel: cycle %0d want 5", sel_chg); end
    tests++;
    if (en_rise != 13) begin fails++; $display("FAIL switch_en_rise: cycle %0d want 13", en_rise); end
    tests++;
    if (done_k != 18) begin fails++; $display("FAIL switch_done: cycle %0d want 18", done_k); end
    tests++;
    if (viol != 0) begin fails++; $display("FAIL switch_sel_while_en: %0d changes want 0", viol); end
    model_sel = 3'd3;
  endtask

  task automatic test_timeout();
    int to_k = -1, done_k = -1;
    ack = 1'b0;
    req_valid = 1'b1; req_sel = 3'd5;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 290; k++) begin
      if (to_k < 0 && tmo === 1'b1) to_k = k;
      if (done_k < 0 && done === 1'b1) done_k = k;
      @(negedge clk);
    end
    tests++;
    if (to_k != 256) begin fails++; $display("FAIL timeout_set: cycle %0d want 256", to_k); end
    tests++;
    if (done_k != 273) begin fails++; $display("FAIL timeout_done: cycle %0d want 273", done_k); end
    tests++;
    if (sel_clk !== 3'd5 || tmo !== 1'b1) begin
      fails++; $display("FAIL timeout_end: sel=%0d to=%b want 5/1", sel_clk, tmo);
    end
    ack = 1'b1;
    req_valid = 1'b1; req_sel = 3'd2;
    @(negedge clk);
    req_valid = 1'b0;
    tests++;
    if (tmo !== 1'b0) begin fails++; $display("FAIL timeout_clear: to=%b want 0", tmo); end
    repeat (20) @(negedge clk);
    tests++;
    if (sel_clk !== 3'd2) begin fails++; $display("FAIL timeout_next_sel: got %0d want 2", sel_clk); end
    model_sel = 3'd2; model_to = 1'b0;
  endtask

  task automatic test_reset_mid();
    int done_k = -1;
    ack = 1'b1;
    req_valid = 1'b1; req_sel = 3'd4;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (7) @(negedge clk);
    tests++;
    if (sel_clk !== 3'd4 || en !== 1'b0) begin
      fails++; $display("FAIL midrst_in_switch: sel=%0d en=%b want 4/0", sel_clk, en);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (sel_clk !== 3'd1 || en !== 1'b1 || busy !== 1'b0 || qreq !== 1'b0) begin
      fails++; $display("FAIL midrst_async: sel=%0d en=%b busy=%b qreq=%b want 1/1/0/0", sel_clk, en, busy, qreq);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_sel = 3'd2;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 22; k++) begin
      if (done_k < 0 && done === 1'b1) done_k = k;
      @(negedge clk);
    end
    tests++;
    if (done_k != 18 || sel_clk !== 3'd2) begin
      fails++; $display("FAIL midrst_fresh: done cycle %0d sel=%0d want 18/2", done_k, sel_clk);
    end
    model_sel = 3'd2; model_to = 1'b0;
  endtask

  // Random requests against a timeline model: with quiesce finishing q edges after
  // accept, the gate closes at q, the select moves at q+4, the gate reopens at q+12,
  // quiesce drops at q+16 and done pulses at q+17.
  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      logic [2:0] sel;
      int d, q, len, r;
      logic is_err, is_same, is_seq, tmo_exp;
      logic [9:0] got, exp;
      sel = 3'($urandom_range(0, 7));
      r = $urandom_range(0, 9);
      d = (r == 0) ? 300 : (r < 4) ? 1 : $urandom_range(1, 30);
      q = (d > 256) ? 256 : d;
      tmo_exp = (d > 256);
      is_err  = (sel >= 3'd6);
      is_same = !is_err && (sel == model_sel);
      is_seq  = !is_err && !is_same;
      len = is_seq ? q + 18 : 2;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ack = 1'b0;
      req_valid = 1'b1; req_sel = sel;
      @(negedge clk);
      req_valid = 1'b0;
      for (int k = 0; k <= len; k++) begin
        if (is_seq) begin
          exp = {((k >= q + 4) ? sel : model_sel),
                 !(k >= q && k < q + 12),
                 (k < q + 16),
                 (k < q + 17),
                 (k == q + 17),
                 1'b0,
                 (k >= q + 17),
                 (tmo_exp && k >= q)};
        end else begin
          exp = {model_sel, 1'b1, 1'b0, 1'b0, (is_same && k == 0), (is_err && k == 0), 1'b1, model_to};
        end
        got = {sel_clk, en, qreq, busy, done, err, req_ready, tmo};
        tests++;
        if (got !== exp) begin
          fails++;
          $display("FAIL rand_trace it=%0d sel=%0d k=%0d {sel,en,qreq,busy,done,err,rdy,to} got %b want %b",
                   it, sel, k, got, exp);
        end
        if (is_seq) begin
          ack = (k + 1 < d) ? 1'b0 : (k + 1 == d) ? 1'b1 : 1'($urandom_range(0, 1));
          req_valid = (k < q + 16) ? 1'($urandom_range(0, 1)) : 1'b0;
          req_sel = 3'($urandom_range(0, 7));
        end
        @(negedge clk);
      end
      req_valid = 1'b0;
      if (is_seq) begin
        model_sel = sel;
        model_to  = tmo_exp;
      end
    end
  endtask

  initial begin
    test_reset();
    test_invalid();
    test_same_sel();
    test_switch();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
